plot_writer: RTL and testbench
==============================

PLOT_WRITER -- requirements
Module: plot_writer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.
- COLOUR_W, 3, colour bits.
- BG_COLOUR, 3'b000, colour written for clear-port pixels.
- DEPTH, 4, pixel buffer entries (power of two).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- clr_valid, in, 1, clear engine offers a pixel.
- clr_x, in, 8, clear engine column.
- clr_y, in, 8, clear engine row.
- clr_ready, out, 1, clear pixel accepted this cycle when high with clr_valid.
- drw_valid, in, 1, draw engine offers a pixel.
- drw_x, in, 8, draw engine column.
- drw_y, in, 8, draw engine row.
- drw_colour, in, COLOUR_W, draw pixel colour.
- drw_ready, out, 1, draw pixel accepted when high with drw_valid.
- vga_x, out, 8, framebuffer column.
- vga_y, out, 7, framebuffer row.
- vga_colour, out, COLOUR_W, framebuffer colour.
- vga_plot, out, 1, one-cycle framebuffer write strobe.
- vga_busy, in, 1, framebuffer cannot accept a write this cycle.
- drop_count, out, 16, saturating count of out-of-range pixels.
- idle, out, 1, buffer empty and no write in flight.

Function
REQ-003 Arbitration: fixed priority, clear over draw, decided per cycle; a port's ready SHALL be high only when it wins and the buffer is not full.
REQ-004 Buffer not-full SHALL depend only on the current occupancy; a same-cycle pop SHALL NOT free space for that cycle's push.
REQ-005 On acceptance, the pixel SHALL be range-checked: x < SCREEN_W and y < SCREEN_H.
REQ-006 An in-range pixel SHALL be pushed into the FIFO as {x, y[6:0], colour}; clear-port pixels SHALL use BG_COLOUR.
REQ-007 An out-of-range pixel SHALL still be accepted (ready high) and SHALL NOT be pushed; drop_count SHALL increment by 1 and saturate at 16'hFFFF.
REQ-008 Pop: on any edge where the FIFO is non-empty and vga_busy is low, the head SHALL be popped into registered vga_x/vga_y/vga_colour, with vga_plot=1 for the following cycle.
REQ-009 Otherwise vga_plot SHALL be 0 and vga_x/vga_y/vga_colour SHALL hold their last values.
REQ-010 Latency: a pixel accepted at edge E into an empty FIFO with vga_busy low SHALL show vga_plot=1 in the cycle after edge E+1.
REQ-011 Sustained throughput SHALL be one pixel per cycle when vga_busy is low.
REQ-012 Pixels SHALL reach the framebuffer in acceptance order.
REQ-013 idle SHALL equal (FIFO empty) AND (vga_plot == 0).
REQ-014 FIFO read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with one extra bit to distinguish full from empty.

Reset
REQ-015 While reset is low: FIFO empty, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, drop_count=0, clr_ready=0, drw_ready=0, idle=1.
REQ-016 Reset asserted mid-operation SHALL discard all buffered pixels immediately; no write strobe SHALL follow the deassertion of reset until a new pixel is accepted.

Structure
REQ-017 Shared package vga_pkg SHALL hold SCREEN_W, SCREEN_H, COLOUR_W, BG_COLOUR and the packed pixel type {x[7:0], y[6:0], colour}.
REQ-018 The buffer SHALL be a separate sub-module, plot_fifo (synchronous, DEPTH entries, push/pop/full/empty outputs).

Verification
REQ-019 Clear only: clr_valid=1 sweeping (0,0)..(3,0), vga_busy=0 -> four strobes, colour 000, first strobe in the cycle after the second edge, then one per cycle.
REQ-020 Contention: clr_valid=drw_valid=1 for 3 cycles -> clr_ready=1 and drw_ready=0 in all 3 cycles; draw pixel (5,7,3'b101) is written after clr_valid drops.
REQ-021 Range check: draw (160,0), (0,120), (159,119) -> first two dropped with drop_count=2; exactly one strobe, at (159,119).
REQ-022 Backpressure: vga_busy=1 while 6 pixels are offered -> 4 accepted, ready low thereafter, vga_plot=0; release vga_busy -> 4 strobes in order, then the remaining 2 are accepted.
REQ-023 Reset mid-burst: assert reset with 3 pixels buffered -> outputs zero and idle=1 within the same cycle; no strobes after release.
REQ-024 Saturation: force 65537 out-of-range pixels -> drop_count holds at 16'hFFFF.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA plot writer.
//   SCREEN_W / SCREEN_H : visible framebuffer size in pixels
//   COLOUR_W            : colour bits per pixel
//   BG_COLOUR           : colour used for pixels coming from the clear engine
//   pixel_t             : packed framebuffer write {x, y, colour}
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

  typedef struct packed {
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

endpackage

// File: rtl/plot_fifo.sv
// Synchronous pixel buffer between the arbiter and the framebuffer port.
//   clk, reset : clock, asynchronous active-low reset (empties the buffer)
//   push, din  : write one entry (ignored when full)
//   pop, dout  : dout is the current head; pop discards it (ignored when empty)
//   full/empty : derived from the registered occupancy only, so a pop in
//                the same cycle never makes room for that cycle's push
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module plot_fifo
  import vga_pkg::*;
#(
  parameter int W     = PIXEL_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plot_writer.sv
// Merges pixels from a clear engine and a draw engine into one framebuffer
// write port.
//   clk, reset          : clock, asynchronous active-low reset
//   clr_valid/x/y/ready : clear engine pixel stream (written in BG_COLOUR)
//   drw_valid/x/y/colour/ready : draw engine pixel stream
//   vga_x/y/colour/plot : registered framebuffer write, plot is a 1-cycle strobe
//   vga_busy            : framebuffer stalls the write port this cycle
//   drop_count          : saturating count of accepted out-of-range pixels
//   idle                : nothing buffered and no strobe being presented
// Clear has fixed priority over draw. Out-of-range pixels are consumed but
// never buffered.
module plot_writer
  import vga_pkg::*;
#(
  parameter int                  SCREEN_W  = vga_pkg::SCREEN_W,
  parameter int                  SCREEN_H  = vga_pkg::SCREEN_H,
  parameter int                  COLOUR_W  = vga_pkg::COLOUR_W,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = vga_pkg::BG_COLOUR,
  parameter int                  DEPTH     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_valid,
  input  logic [7:0]          clr_x,
  input  logic [7:0]          clr_y,
  output logic                clr_ready,
  input  logic                drw_valid,
  input  logic [7:0]          drw_x,
  input  logic [7:0]          drw_y,
  input  logic [COLOUR_W-1:0] drw_colour,
  output logic                drw_ready,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  input  logic                vga_busy,
  output logic [15:0]         drop_count,
  output logic                idle
);

  localparam int PW = 8 + 7 + COLOUR_W;

  logic                accept;
  logic                in_range;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [7:0]          sel_x;
  logic [7:0]          sel_y;
  logic [COLOUR_W-1:0] sel_colour;
  logic [PW-1:0]       push_data;
  logic [PW-1:0]       head;

  // Ready is gated by reset too: full reads 0 during reset, but nothing may
  // be accepted while the block is held in reset.
  always_comb begin
    clr_ready  = reset & clr_valid & ~full;
    drw_ready  = reset & drw_valid & ~clr_valid & ~full;
    accept     = clr_ready | drw_ready;
    sel_x      = drw_x;
    sel_y      = drw_y;
    sel_colour = drw_colour;
    if (clr_valid) begin
      sel_x      = clr_x;
      sel_y      = clr_y;
      sel_colour = BG_COLOUR;
    end
    in_range  = (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);
    push      = accept & in_range;
    push_data = {sel_x, sel_y[6:0], sel_colour};
    pop       = ~empty & ~vga_busy;
  end

  plot_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= pop;
      if (pop) begin
        vga_x      <= head[PW-1 -: 8];
        vga_y      <= head[COLOUR_W +: 7];
        vga_colour <= head[COLOUR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (accept && !in_range && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign idle = empty & ~vga_plot;

endmodule

// File: tb/tb_plot_writer.sv
module tb_plot_writer;
  import vga_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr_valid = 1'b0;
  logic [7:0] clr_x = '0, clr_y = '0;
  logic       clr_ready;
  logic       drw_valid = 1'b0;
  logic [7:0] drw_x = '0, drw_y = '0;
  logic [2:0] drw_colour = '0;
  logic       drw_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       vga_busy = 1'b0;
  logic [15:0] drop_count;
  logic       idle;

  plot_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .clr_valid(clr_valid), .clr_x(clr_x), .clr_y(clr_y), .clr_ready(clr_ready),
    .drw_valid(drw_valid), .drw_x(drw_x), .drw_y(drw_y), .drw_colour(drw_colour),
    .drw_ready(drw_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .vga_busy(vga_busy), .drop_count(drop_count), .idle(idle)
  );

  always #5 clk = ~clk;

  // Reference model: buffered pixels, expected framebuffer writes in order,
  // one expected-strobe bit per clock edge, and the drop counter.
  pixel_t mfifo[$];
  pixel_t sb[$];
  bit     exp_plot_q[$];
  int     m_drop = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_accept(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    pixel_t p;
    if (int'(x) < SCREEN_W && int'(y) < SCREEN_H) begin
      p.x = x;
      p.y = y[6:0];
      p.colour = c;
      mfifo.push_back(p);
    end else if (m_drop < 65535) begin
      m_drop++;
    end
  endfunction

  // One clock cycle: inputs applied now (just after a rising edge), ready
  // checked at the falling edge, model advanced for the coming rising edge.
  task automatic step(input bit cv, input logic [7:0] cx, input logic [7:0] cy,
                      input bit dv, input logic [7:0] dx, input logic [7:0] dy,
                      input logic [2:0] dc, input bit busy,
                      output bit c_acc, output bit d_acc);
    bit nf, ec, ed, pop;
    clr_valid = cv; clr_x = cx; clr_y = cy;
    drw_valid = dv; drw_x = dx; drw_y = dy; drw_colour = dc;
    vga_busy = busy;
    @(negedge clk);
    nf = mfifo.size() < DEPTH;
    ec = cv && nf;
    ed = dv && !cv && nf;
    check("clr_ready", clr_ready, ec);
    check("drw_ready", drw_ready, ed);
    pop = (mfifo.size() > 0) && !busy;
    if (pop) sb.push_back(mfifo.pop_front());
    exp_plot_q.push_back(pop);
    if (ec) model_accept(cx, cy, BG_COLOUR);
    else if (ed) model_accept(dx, dy, dc);
    c_acc = ec;
    d_acc = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit busy);
    bit a, b;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, busy, a, b);
  endtask

  // Monitor: compares what the DUT presents after each rising edge.
  initial begin
    bit e;
    pixel_t p;
    forever begin
      @(posedge clk);
      #2;
      if (exp_plot_q.size() > 0) begin
        e = exp_plot_q.pop_front();
        check("vga_plot", vga_plot, e);
        if (e && sb.size() > 0) begin
          p = sb.pop_front();
          check("pixel", {vga_x, vga_y, vga_colour}, p);
        end
        check("idle", idle, (mfifo.size() == 0) && !e);
        check("drop_count", drop_count, m_drop);
      end else if (vga_plot) begin
        check("spurious_plot", vga_plot, 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plot"}, vga_plot, 0);
    check({tag, "_vga"}, {vga_x, vga_y, vga_colour}, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_clr_ready"}, clr_ready, 0);
    check({tag, "_drw_ready"}, drw_ready, 0);
  endtask

  initial begin
    bit a, b;
    int idx;
    logic [7:0] px [6];
    logic [7:0] py [6];

    clr_valid = 1'b1; drw_valid = 1'b1;
    #3;
    check_reset_outputs("reset");
    clr_valid = 1'b0; drw_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Clear sweep (0,0)..(3,0).
    for (int i = 0; i < 4; i++) step(1, 8'(i), 0, 0, 0, 0, 0, 0, a, b);
    idle_cycles(4, 0);

    // Contention for 3 cycles, then the held draw pixel goes through.
    for (int i = 0; i < 3; i++) step(1, 8'(10 + i), 1, 1, 5, 7, 3'b101, 0, a, b);
    b = 0;
    for (int i = 0; i < 5 && !b; i++) step(0, 0, 0, 1, 5, 7, 3'b101, 0, a, b);
    idle_cycles(4, 0);

    // Range check.
    step(0, 0, 0, 1, 160, 0, 3'b111, 0, a, b);
    step(0, 0, 0, 1, 0, 120, 3'b111, 0, a, b);
    step(0, 0, 0, 1, 159, 119, 3'b110, 0, a, b);
    idle_cycles(4, 0);

    // Backpressure: 6 pixels held on the draw port, framebuffer busy first.
    for (int i = 0; i < 6; i++) begin px[i] = 8'(20 + i); py[i] = 8'(30 + i); end
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (idx < 6) step(0, 0, 0, 1, px[idx], py[idx], 3'(idx), cyc < 8, a, b);
      else step(0, 0, 0, 0, 0, 0, 0, cyc < 8, a, b);
      if (b) idx++;
    end
    idle_cycles(3, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 170)), 8'($urandom_range(0, 130)),
           $urandom_range(0, 1) == 1, 8'($urandom_range(0, 170)), 8'($urandom_range(0, 130)),
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 3, a, b);
    end
    idle_cycles(8, 0);

    // Reset mid-burst with 3 pixels buffered.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'(40 + i), 8'(50 + i), 3'b011, 1, a, b);
    mfifo.delete(); sb.delete(); exp_plot_q.delete(); m_drop = 0;
    reset = 1'b0;
    clr_valid = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); @(posedge clk); #1;
    clr_valid = 1'b0;
    reset = 1'b1;
    idle_cycles(6, 0);

    // Drop counter saturation.
    for (int i = 0; i < 65537; i++) step(1, 200, 0, 0, 0, 0, 0, 0, a, b);
    idle_cycles(3, 0);
    check("drop_sat", drop_count, 16'hFFFF);

    @(posedge clk); #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
